// File: rtl/mem_pkg.sv
// Shared definitions for the non-blocking memory stage: one-hot op bit
// positions, request size codes, exception code and the in-flight tag layout.
package mem_pkg;

  localparam int MEMOP_LDB  = 0;
  localparam int MEMOP_LDH  = 1;
  localparam int MEMOP_LDW  = 2;
  localparam int MEMOP_LDBU = 3;
  localparam int MEMOP_LDHU = 4;
  localparam int MEMOP_STB  = 5;
  localparam int MEMOP_STH  = 6;
  localparam int MEMOP_STW  = 7;

  localparam logic [5:0] ECODE_ALE = 6'h09;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  // kill is stored as 0; flush kills are tracked as a head-side count in the stage
  typedef struct packed {
    logic       is_load;
    logic [4:0] op;
    logic [1:0] a;
    logic       kill;
  } tag_t;

  function automatic size_e op_size(input logic [7:0] op);
    if (op[MEMOP_LDW] || op[MEMOP_STW]) return SIZE_W;
    if (op[MEMOP_LDH] || op[MEMOP_LDHU] || op[MEMOP_STH]) return SIZE_H;
    return SIZE_B;
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// In-order DEPTH x WIDTH synchronous FIFO with show-ahead head, clear and
// occupancy count. Used for both the load-response queue and the tag queue.
module mem_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_count != FULL);
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push && !i_clr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/mem_nb_stage.sv
// Non-blocking MEM stage: issues loads/stores without waiting for data_ok and
// returns load data through an in-order response FIFO. `MEM_ALIGN_CHECK_EN
// enables misaligned-access (ALE) detection.
module mem_nb_stage
  import mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [7:0]      in_mem_op,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wval,
  input  logic            in_exc,
  input  logic            flush,
  output logic            req,
  output logic            wr,
  output logic [1:0]      size,
  output logic [XLEN-1:0] addr,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  input  logic            addr_ok,
  input  logic            data_ok,
  input  logic [XLEN-1:0] rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic            out_is_load,
  output logic            out_exc,
  output logic [5:0]      out_ecode,
  output logic [XLEN-1:0] out_badv,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  input  logic            resp_ready,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            w_ale;
  logic            w_is_load_op;
  logic            w_mem;
  logic            w_room;
  logic            w_ready_go;
  logic            w_fire;
  logic [CW-1:0]   w_inflight;
  logic [CW-1:0]   w_resp_cnt;
  logic [CW:0]     w_occ;
  tag_t            w_tag_in;
  tag_t            w_head;
  logic            w_tag_empty;
  logic            w_tag_push;
  logic            w_tag_pop;
  logic            w_head_kill;
  logic            w_resp_push;
  logic            w_resp_empty;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_ext;
  logic [CW-1:0]   r_kill_cnt;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_pc;
  logic            r_out_is_load;
  logic            r_out_exc;
  logic [5:0]      r_out_ecode;
  logic [XLEN-1:0] r_out_badv;

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    w_ale = 1'b0;
    if ((in_mem_op[MEMOP_LDH] || in_mem_op[MEMOP_LDHU] || in_mem_op[MEMOP_STH]) && in_addr[0])
      w_ale = 1'b1;
    if ((in_mem_op[MEMOP_LDW] || in_mem_op[MEMOP_STW]) && (in_addr[1:0] != 2'b00))
      w_ale = 1'b1;
  end
`else
  assign w_ale = 1'b0;
`endif

  assign w_is_load_op = |in_mem_op[4:0];
  assign w_mem        = in_valid && (|in_mem_op) && !in_exc && !w_ale;
  assign w_occ        = {1'b0, w_inflight} + {1'b0, w_resp_cnt};
  assign w_room       = (w_occ < (CW+1)'(DEPTH));
  assign req          = w_mem && !flush && out_ready && w_room;
  assign w_ready_go   = !in_valid || !w_mem || (req && addr_ok);
  assign in_ready     = !rst && (!in_valid || (w_ready_go && out_ready));
  assign w_fire       = in_valid && w_ready_go && out_ready;

  assign wr   = |in_mem_op[7:5];
  assign size = op_size(in_mem_op);
  assign addr = in_addr;

  always_comb begin
    wstrb = 4'b0000;
    wdata = in_wval;
    if (in_mem_op[MEMOP_STB]) wstrb = 4'b0001 << in_addr[1:0];
    if (in_mem_op[MEMOP_STH]) wstrb = 4'b0011 << in_addr[1:0];
    if (in_mem_op[MEMOP_STW]) wstrb = 4'b1111;
    case (op_size(in_mem_op))
      SIZE_B:  wdata = {(XLEN/8){in_wval[7:0]}};
      SIZE_H:  wdata = {(XLEN/16){in_wval[15:0]}};
      default: wdata = in_wval;
    endcase
  end

  assign w_tag_in   = '{is_load: w_is_load_op, op: in_mem_op[4:0], a: in_addr[1:0], kill: 1'b0};
  assign w_tag_push = req && addr_ok;
  assign w_tag_pop  = data_ok && !w_tag_empty;

  mem_resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(tag_t))
  ) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (1'b0),
    .i_push  (w_tag_push),
    .i_data  (w_tag_in),
    .i_pop   (w_tag_pop),
    .o_data  (w_head),
    .o_empty (w_tag_empty),
    .o_count (w_inflight)
  );

  // Flushed entries are always the oldest ones, so a count from the head marks them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kill_cnt <= '0;
    end else if (flush) begin
      r_kill_cnt <= w_inflight - CW'(w_tag_pop);
    end else if (w_tag_pop && (r_kill_cnt != '0)) begin
      r_kill_cnt <= r_kill_cnt - CW'(1);
    end
  end

  assign w_head_kill = w_head.kill || (r_kill_cnt != '0);
  assign w_resp_push = w_tag_pop && w_head.is_load && !w_head_kill && !flush;
  assign w_shifted   = rdata >> {w_head.a, 3'b000};

  always_comb begin
    w_ext = rdata;
    if (w_head.op[MEMOP_LDB])  w_ext = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
    if (w_head.op[MEMOP_LDH])  w_ext = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
    if (w_head.op[MEMOP_LDBU]) w_ext = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
    if (w_head.op[MEMOP_LDHU]) w_ext = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
  end

  mem_resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_resp_q (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush),
    .i_push  (w_resp_push),
    .i_data  (w_ext),
    .i_pop   (resp_ready),
    .o_data  (resp_data),
    .o_empty (w_resp_empty),
    .o_count (w_resp_cnt)
  );

  assign resp_valid = !w_resp_empty;
  assign busy       = (w_inflight != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_pc      <= '0;
      r_out_is_load <= 1'b0;
      r_out_exc     <= 1'b0;
      r_out_ecode   <= '0;
      r_out_badv    <= '0;
    end else begin
      if (out_ready) r_out_valid <= w_fire && !flush;
      if (w_fire) begin
        r_out_pc      <= in_pc;
        r_out_is_load <= w_mem && w_is_load_op;
        r_out_exc     <= in_exc || w_ale;
        r_out_ecode   <= (w_ale && !in_exc) ? ECODE_ALE : 6'h00;
        r_out_badv    <= (w_ale && !in_exc) ? in_addr : '0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_is_load = r_out_is_load;
  assign out_exc     = r_out_exc;
  assign out_ecode   = r_out_ecode;
  assign out_badv    = r_out_badv;

endmodule

// File: tb/tb_mem_nb_stage.sv
// Self-checking bench for mem_nb_stage: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_mem_nb_stage;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALE_ON = 1'b1;
`else
  localparam bit ALE_ON = 1'b0;
`endif

  logic        clk, rst;
  logic        in_valid, in_ready, in_exc, flush;
  logic [31:0] in_pc, in_addr, in_wval;
  logic [7:0]  in_mem_op;
  logic        req, wr, addr_ok, data_ok;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  logic        out_valid, out_ready, out_is_load, out_exc;
  logic [31:0] out_pc, out_badv;
  logic [5:0]  out_ecode;
  logic        resp_valid, resp_ready, busy;
  logic [31:0] resp_data;

  mem_nb_stage #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_mem_op(in_mem_op), .in_addr(in_addr), .in_wval(in_wval), .in_exc(in_exc),
    .flush(flush), .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_is_load(out_is_load), .out_exc(out_exc), .out_ecode(out_ecode),
    .out_badv(out_badv), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] op;
    logic [1:0] a;
    logic       killed;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] resp_q[$];
  logic        m_out_valid = 1'b0, m_out_is_load = 1'b0, m_out_exc = 1'b0;
  logic [31:0] m_out_pc = '0, m_out_badv = '0;
  logic [5:0]  m_out_ecode = '0;
  logic        last_accept = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [7:0] op);
    if (op[2] || op[7]) return 4;
    if (op[1] || op[4] || op[6]) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] extend(input logic [7:0] op, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (8 * a)) & 32'hFFFF;
    if (op[0]) return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
    if (op[1]) return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
    if (op[3]) return b;
    if (op[4]) return h;
    return d;
  endfunction

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    bit          misal, ale, mem, e_req, rg, e_rdy, push_new;
    int          nb;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, new_val;
    pend_t       p;
    #1;
    nb    = nbytes(in_mem_op);
    misal = (nb == 2 && in_addr[0]) || (nb == 4 && in_addr[1:0] != 2'b00);
    ale   = ALE_ON && misal && (in_mem_op != 8'h00);
    mem   = in_valid && (in_mem_op != 8'h00) && !in_exc && !ale;
    e_req = mem && !flush && out_ready && (pend_q.size() + resp_q.size() < DEPTH);
    rg    = !in_valid || !mem || (e_req && addr_ok);
    e_rdy = !in_valid || (rg && out_ready);
    chk("req", req, 32'(e_req));
    chk("in_ready", in_ready, 32'(e_rdy));
    chk("busy", busy, 32'(pend_q.size() != 0));
    chk("resp_valid", resp_valid, 32'(resp_q.size() != 0));
    if (resp_q.size() != 0) chk("resp_data", resp_data, resp_q[0]);
    if (e_req) begin
      e_strb  = 4'h0;
      if (in_mem_op[7:5] != 3'b000) e_strb = (nb == 4) ? 4'hF : 4'(((1 << nb) - 1) << in_addr[1:0]);
      e_wdata = (nb == 1) ? (in_wval & 32'hFF) * 32'h01010101 :
                (nb == 2) ? (in_wval & 32'hFFFF) * 32'h00010001 : in_wval;
      chk("wr", wr, 32'(in_mem_op[7:5] != 3'b000));
      chk("size", size, (nb == 1) ? 32'd0 : (nb == 2) ? 32'd1 : 32'd2);
      chk("addr", addr, in_addr);
      chk("wstrb", wstrb, 32'(e_strb));
      chk("wdata", wdata, e_wdata);
    end
    push_new = 1'b0;
    new_val  = '0;
    if (data_ok && pend_q.size() != 0) begin
      p = pend_q.pop_front();
      if (p.op[4:0] != 5'b0 && !p.killed && !flush) begin
        push_new = 1'b1;
        new_val  = extend(p.op, p.a, rdata);
      end
    end
    if (resp_ready && resp_q.size() != 0) void'(resp_q.pop_front());
    if (flush) begin
      resp_q.delete();
      for (int i = 0; i < pend_q.size(); i++) pend_q[i].killed = 1'b1;
    end
    if (push_new) resp_q.push_back(new_val);
    if (e_req && addr_ok) begin
      pend_q.push_back('{op: in_mem_op, a: in_addr[1:0], killed: 1'b0});
      $display("req pc=%h op=%h addr=%h", in_pc, in_mem_op, in_addr);
    end
    if (in_valid && rg && out_ready) begin
      m_out_pc      = in_pc;
      m_out_is_load = mem && (in_mem_op[4:0] != 5'b0);
      m_out_exc     = in_exc || ale;
      m_out_ecode   = (ale && !in_exc) ? 6'h09 : 6'h00;
      m_out_badv    = (ale && !in_exc) ? in_addr : 32'h0;
    end
    if (out_ready) m_out_valid = in_valid && rg && !flush;
    last_accept = in_valid && e_rdy;
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", out_valid, 32'(m_out_valid));
    chk("out_pc", out_pc, m_out_pc);
    chk("out_is_load", out_is_load, 32'(m_out_is_load));
    chk("out_exc", out_exc, 32'(m_out_exc));
    chk("out_ecode", out_ecode, 32'(m_out_ecode));
    chk("out_badv", out_badv, m_out_badv);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_mem_op = 8'h00; in_exc = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; flush = 1'b0;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [7:0] op, input logic [31:0] a, input logic [31:0] wv);
    in_valid = 1'b1; in_pc = pc; in_mem_op = op; in_addr = a; in_wval = wv; in_exc = 1'b0;
  endtask

  task automatic load_once(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp);
    set_instr(32'h200, op, a, 32'h0); addr_ok = 1'b1;
    cycle();
    idle(); data_ok = 1'b1; rdata = d;
    cycle();
    data_ok = 1'b0;
    chk(tag, resp_data, exp);
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;
  endtask

  initial begin
    int n;
    bit do_flush;
    rst = 1'b1; idle(); in_pc = '0; in_addr = '0; in_wval = '0; rdata = '0;
    out_ready = 1'b1; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_exc", out_exc, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1);

    // ld.w with delayed data_ok
    set_instr(32'h100, 8'h04, 32'h1000, 32'h0); addr_ok = 1'b1;
    #1 chk("t1_req", req, 1);
    cycle();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_is_load", out_is_load, 1);
    idle(); cycle(); cycle();
    data_ok = 1'b1; rdata = 32'hDEADBEEF;
    cycle();
    data_ok = 1'b0;
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_resp_data", resp_data, 32'hDEADBEEF);
    resp_ready = 1'b1; cycle(); resp_ready = 1'b0;

    load_once("t2_ldb", 8'h01, 32'h1003, 32'h80FF0000, 32'hFFFFFF80);
    load_once("t3_ldbu", 8'h08, 32'h1003, 32'h80FF0000, 32'h00000080);

    // st.h strobes/data, response not forwarded
    set_instr(32'h300, 8'h40, 32'h2002, 32'h1234ABCD); addr_ok = 1'b1;
    #1;
    chk("t4_wr", wr, 1);
    chk("t4_size", size, 1);
    chk("t4_wstrb", wstrb, 4'b1100);
    chk("t4_wdata", wdata, 32'hABCDABCD);
    cycle();
    idle(); data_ok = 1'b1; rdata = 32'h5555AAAA;
    cycle();
    data_ok = 1'b0;
    chk("t4_resp_valid", resp_valid, 0);

    // Three back-to-back loads against DEPTH=2
    set_instr(32'h400, 8'h04, 32'h3000, 32'h0); addr_ok = 1'b1; cycle();
    set_instr(32'h404, 8'h04, 32'h3004, 32'h0); cycle();
    set_instr(32'h408, 8'h04, 32'h3008, 32'h0);
    #1;
    chk("t5_c_req", req, 0);
    chk("t5_c_in_ready", in_ready, 0);
    cycle(); cycle();
    data_ok = 1'b1; rdata = 32'hAAAA0001; cycle(); data_ok = 1'b0;
    chk("t5_a_data", resp_data, 32'hAAAA0001);
    resp_ready = 1'b1;
    n = 0;
    last_accept = 1'b0;
    while (!last_accept && n < 10) begin cycle(); n++; end
    chk("t5_c_accepted", 32'(last_accept), 1);
    idle();
    data_ok = 1'b1; rdata = 32'hBBBB0002; cycle();
    chk("t5_b_data", resp_data, 32'hBBBB0002);
    rdata = 32'hCCCC0003; cycle();
    data_ok = 1'b0;
    chk("t5_c_data", resp_data, 32'hCCCC0003);
    cycle();

    // flush drops two outstanding loads
    set_instr(32'h500, 8'h04, 32'h4000, 32'h0); addr_ok = 1'b1; cycle();
    set_instr(32'h504, 8'h04, 32'h4004, 32'h0); cycle();
    idle(); flush = 1'b1; cycle(); flush = 1'b0;
    data_ok = 1'b1; rdata = 32'h11111111; cycle();
    chk("t6_drop1", resp_valid, 0);
    rdata = 32'h22222222; cycle();
    chk("t6_drop2", resp_valid, 0);
    data_ok = 1'b0;
    chk("t6_busy", busy, 0);
    resp_ready = 1'b0;
    load_once("t6_after_flush", 8'h02, 32'h4008, 32'h00008001, 32'hFFFF8001);

    // instruction carrying an exception
    set_instr(32'h600, 8'h04, 32'h5000, 32'h0); in_exc = 1'b1; addr_ok = 1'b1;
    #1 chk("exc_req", req, 0);
    cycle();
    chk("exc_out_exc", out_exc, 1);
    chk("exc_ecode", out_ecode, 0);
    chk("exc_is_load", out_is_load, 0);
    idle(); cycle();

    // misaligned ld.w
    set_instr(32'h700, 8'h04, 32'h1002, 32'h0); addr_ok = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
    #1 chk("ale_req", req, 0);
    cycle();
    chk("ale_exc", out_exc, 1);
    chk("ale_ecode", out_ecode, 6'h09);
    chk("ale_badv", out_badv, 32'h1002);
    idle(); cycle();
`else
    #1 chk("misal_req", req, 1);
    cycle();
    chk("misal_exc", out_exc, 0);
    idle(); data_ok = 1'b1; rdata = 32'h0BADF00D; cycle();
    data_ok = 1'b0; resp_ready = 1'b1; cycle(); resp_ready = 1'b0;
`endif

    // random traffic
    do_flush = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!(in_valid && !last_accept) || do_flush) begin
        int r;
        in_valid = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        in_mem_op = (r < 8) ? 8'(1 << r) : 8'h00;
        in_addr = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          if (nbytes(in_mem_op) == 2) in_addr[0] = 1'b0;
          if (nbytes(in_mem_op) == 4) in_addr[1:0] = 2'b00;
        end
        in_pc = $urandom; in_wval = $urandom;
        in_exc = ($urandom_range(0, 15) == 0);
      end
      addr_ok    = ($urandom_range(0, 2) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 1) != 0);
      do_flush   = ($urandom_range(0, 24) == 0);
      flush      = do_flush;
      data_ok    = (pend_q.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      rdata      = $urandom;
      cycle();
    end

    idle(); out_ready = 1'b1; resp_ready = 1'b1;
    n = 0;
    while (pend_q.size() != 0 && n < 20) begin
      data_ok = 1'b1; rdata = $urandom; cycle(); n++;
    end
    data_ok = 1'b0;
    cycle(); cycle();
    chk("drain_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
